// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: ALU operation codes, base opcodes, control states,
// instruction classes and the PC / write-back select values.
package rv32i_pkg;

    typedef enum logic [4:0] {
        ALU_LUI   = 5'd0,
        ALU_AUIPC = 5'd1,
        ALU_ADD   = 5'd2,
        ALU_BEQ   = 5'd3,
        ALU_BNE   = 5'd4,
        ALU_BLT   = 5'd5,
        ALU_BGE   = 5'd6,
        ALU_BLTU  = 5'd7,
        ALU_BGEU  = 5'd8,
        ALU_SLT   = 5'd9,
        ALU_SLTU  = 5'd10,
        ALU_XOR   = 5'd11,
        ALU_OR    = 5'd12,
        ALU_AND   = 5'd13,
        ALU_SLL   = 5'd14,
        ALU_SRL   = 5'd15,
        ALU_SRA   = 5'd16,
        ALU_SUB   = 5'd17,
        ALU_NOP   = 5'd18
    } alu_op_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_e;

    // CL_ALU covers everything that writes alu_out back: OP, OP-IMM, LUI, AUIPC.
    typedef enum logic [2:0] {
        CL_ALU, CL_JUMP, CL_BRANCH, CL_LOAD, CL_STORE, CL_NOP
    } instr_class_e;

    localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    // Register and immediate arithmetic share one table; only the register form has SUB.
    function automatic alu_op_e arith_alu_op(input logic [2:0] funct3,
                                             input logic       is_reg,
                                             input logic       funct7_5);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode: ALU operation, operand selects, instruction class
// and legality from a raw instruction word.
module alu_op_decode
    import rv32i_pkg::*;
(
    input  logic [31:0]  instr,
    output alu_op_e      alu_op,
    output logic         src1_sel,
    output logic         src2_sel,
    output instr_class_e iclass,
    output logic         legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7_5    = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        alu_op   = ALU_NOP;
        src1_sel = 1'b0;
        src2_sel = (opcode != OPC_OP);
        iclass   = CL_NOP;
        legal    = 1'b1;
        case (opcode)
            OPC_OP: begin
                alu_op = arith_alu_op(funct3, 1'b1, funct7_5);
                iclass = CL_ALU;
            end
            OPC_OP_IMM: begin
                alu_op = arith_alu_op(funct3, 1'b0, funct7_5);
                iclass = CL_ALU;
            end
            OPC_LUI: begin
                alu_op = ALU_LUI;
                iclass = CL_ALU;
            end
            OPC_AUIPC: begin
                alu_op   = ALU_AUIPC;
                src1_sel = 1'b1;
                iclass   = CL_ALU;
            end
            OPC_JAL: begin
                alu_op   = ALU_ADD;
                src1_sel = 1'b1;
                iclass   = CL_JUMP;
            end
            OPC_JALR: begin
                alu_op = ALU_ADD;
                iclass = CL_JUMP;
            end
            OPC_LOAD: begin
                alu_op = ALU_ADD;
                iclass = CL_LOAD;
            end
            OPC_STORE: begin
                alu_op = ALU_ADD;
                iclass = CL_STORE;
            end
            OPC_BRANCH: begin
                iclass = CL_BRANCH;
                case (funct3)
                    3'b000: alu_op = ALU_BEQ;
                    3'b001: alu_op = ALU_BNE;
                    3'b100: alu_op = ALU_BLT;
                    3'b101: alu_op = ALU_BGE;
                    3'b110: alu_op = ALU_BLTU;
                    3'b111: alu_op = ALU_BGEU;
                    default: begin
                        iclass = CL_NOP;
                        legal  = 1'b0;
                    end
                endcase
            end
            OPC_FENCE, OPC_SYSTEM: iclass = CL_NOP;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_control_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing
// with an optional halting TRAP state for illegal instructions.
module rv32i_control_fsm
    import rv32i_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [4:0]  ALU_op,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        imem_req,
    output logic        trap,
    output logic        src1_sel,
    output logic        src2_sel,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state
);

    state_e       state_q, state_d;
    logic [31:0]  ir_q, ir_d;
    alu_op_e      alu_op_q, alu_op_d;
    logic         src1_q, src1_d;
    logic         src2_q, src2_d;
    instr_class_e iclass_q, iclass_d;

    alu_op_e      dec_alu_op;
    logic         dec_src1, dec_src2, dec_legal;
    instr_class_e dec_iclass;

    alu_op_decode u_decode (
        .instr    (ir_q),
        .alu_op   (dec_alu_op),
        .src1_sel (dec_src1),
        .src2_sel (dec_src2),
        .iclass   (dec_iclass),
        .legal    (dec_legal)
    );

    always_comb begin
        ir_d     = ir_q;
        alu_op_d = alu_op_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        iclass_d = iclass_q;
        if (state_q == S_FETCH && mem_ready) begin
            ir_d = instr;
        end
        if (state_q == S_DECODE) begin
            alu_op_d = dec_alu_op;
            src1_d   = dec_src1;
            src2_d   = dec_src2;
            iclass_d = dec_iclass;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        imem_req  = 1'b0;
        trap      = 1'b0;
        pc_sel    = PC_SEL_SEQ;
        wb_sel    = WB_SEL_ALU;
        case (state_q)
            S_FETCH: begin
                // Reset also parks the FSM here, so the fetch outputs stay quiet until rst drops.
                if (!rst) begin
                    imem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                state_d = (!dec_legal && ILLEGAL_HALT) ? S_TRAP : S_EXECUTE;
            end
            S_EXECUTE: begin
                case (iclass_q)
                    CL_BRANCH: begin
                        pc_write = 1'b1;
                        pc_sel   = zero ? PC_SEL_BRANCH : PC_SEL_SEQ;
                        state_d  = S_FETCH;
                    end
                    CL_NOP: begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                    CL_LOAD, CL_STORE: state_d = S_MEMORY;
                    default:           state_d = S_WRITEBACK;
                endcase
            end
            S_MEMORY: begin
                if (iclass_q == CL_LOAD) begin
                    mem_read = 1'b1;
                    if (mem_ready) state_d = S_WRITEBACK;
                end else begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (iclass_q == CL_LOAD) begin
                    wb_sel = WB_SEL_LOAD;
                end else if (iclass_q == CL_JUMP) begin
                    wb_sel = WB_SEL_LINK;
                    pc_sel = PC_SEL_JUMP;
                end
                state_d = S_FETCH;
            end
            S_TRAP: trap = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            alu_op_q <= ALU_NOP;
            src1_q   <= 1'b0;
            src2_q   <= 1'b0;
            iclass_q <= CL_NOP;
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            iclass_q <= iclass_d;
        end
    end

    // NOTE: the IR is pure datapath, always loaded in FETCH before use, so it carries no reset.
    always_ff @(posedge clk) begin
        ir_q <= ir_d;
    end

    assign ALU_op   = alu_op_q;
    assign src1_sel = src1_q;
    assign src2_sel = src2_q;
    assign state    = state_q;

endmodule
